// File: rtl/uart_autobaud.sv
// uart_autobaud: auto-baud controller for the variable-oversampling UART receiver.
// Measures the bit period of an incoming sync character (default 0x55) on the
// raw RX line, derives the oversampling ratio and drives it to the receiver.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   in       in   raw asynchronous RX line (shared with the receiver)
//   rx_out   in   receiver byte output
//   rx_clk   in   receiver byte strobe; rising edge marks a valid rx_out
//   relearn  in   one-cycle request to restart hunting
//   o        out  oversampling ratio (clk cycles per bit)
//   locked   out  high while a ratio is confirmed
//   err      out  one-cycle pulse on any abort
//
// Build option: define UART_AUTOBAUD_VERIFY_EN to confirm lock by checking the
// receiver's next decoded byte against SYNC. Without it, a successful
// measurement locks immediately and rx_out/rx_clk are unused.
module uart_autobaud #(
  parameter int unsigned OW       = 4,
  parameter int unsigned CW       = 16,
  parameter int unsigned DEF_O    = 8,
  parameter int unsigned IDLE_MIN = 16,
  parameter logic [7:0]  SYNC     = 8'h55
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in,
  input  logic [7:0]    rx_out,
  input  logic          rx_clk,
  input  logic          relearn,
  output logic [OW-1:0] o,
  output logic          locked,
  output logic          err
);

  typedef enum logic [1:0] {HUNT, MEASURE, VERIFY, LOCKED} state_t;

  // The interval counter aborts instead of stepping onto all-ones, so a
  // measured interval always fits in CW bits and eight of them in CW+3 bits.
  localparam logic [CW-1:0] INT_LAST = {{(CW-1){1'b1}}, 1'b0};

  state_t        state_q, state_d;
  logic          s1_q, rxs_q, rxs_prev_q, rxclk_prev_q;
  logic [CW-1:0] idle_q, idle_d;
  logic [CW-1:0] int_q, int_d;
  logic [CW-1:0] t0_q, t0_d;
  logic [CW+2:0] sum_q, sum_d;
  logic [2:0]    k_q, k_d;
  logic [OW-1:0] o_q, o_d, o_sav_q, o_sav_d;
  logic          err_q, err_d;

  logic          edge_w, fall_w, strobe_w, abort_w;
  logic [CW-1:0] t_w, diff_w;
  logic [CW+2:0] sum_nx_w;
  logic [CW:0]   r_w;

`ifdef UART_AUTOBAUD_VERIFY_EN
  logic          miss_q, miss_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
`else
  logic          unused_rx;
  assign unused_rx = ^{rx_out, rx_clk};
`endif

  assign edge_w   = rxs_q ^ rxs_prev_q;
  assign fall_w   = rxs_prev_q & ~rxs_q;
  assign strobe_w = rx_clk & ~rxclk_prev_q;
  assign t_w      = int_q + CW'(1);
  assign diff_w   = (t_w > t0_q) ? (t_w - t0_q) : (t0_q - t_w);
  assign sum_nx_w = sum_q + (CW+3)'(t_w);
  assign r_w      = (CW+1)'(({1'b0, sum_nx_w} + (CW+4)'(4)) >> 3);

  assign o      = o_q;
  assign locked = (state_q == LOCKED);
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      rxclk_prev_q <= 1'b0;
      state_q      <= HUNT;
      idle_q       <= '0;
      int_q        <= '0;
      t0_q         <= '0;
      sum_q        <= '0;
      k_q          <= '0;
      o_q          <= OW'(DEF_O);
      o_sav_q      <= OW'(DEF_O);
      err_q        <= 1'b0;
`ifdef UART_AUTOBAUD_VERIFY_EN
      miss_q       <= 1'b0;
      vcnt_q       <= '0;
`endif
    end else begin
      s1_q         <= in;
      rxs_q        <= s1_q;
      rxs_prev_q   <= rxs_q;
      rxclk_prev_q <= rx_clk;
      state_q      <= state_d;
      idle_q       <= idle_d;
      int_q        <= int_d;
      t0_q         <= t0_d;
      sum_q        <= sum_d;
      k_q          <= k_d;
      o_q          <= o_d;
      o_sav_q      <= o_sav_d;
      err_q        <= err_d;
`ifdef UART_AUTOBAUD_VERIFY_EN
      miss_q       <= miss_d;
      vcnt_q       <= vcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    t0_d    = t0_q;
    sum_d   = sum_q;
    k_d     = k_q;
    o_d     = o_q;
    o_sav_d = o_sav_q;
    err_d   = 1'b0;
    abort_w = 1'b0;
`ifdef UART_AUTOBAUD_VERIFY_EN
    miss_d  = miss_q;
    vcnt_d  = vcnt_q;
`endif

    // Saturating run length of idle (high) line.
    if (!rxs_q)             idle_d = '0;
    else if (idle_q == '1)  idle_d = idle_q;
    else                    idle_d = idle_q + CW'(1);

    case (state_q)
      HUNT: begin
        if (fall_w && (idle_q >= CW'(IDLE_MIN))) begin
          state_d = MEASURE;
          int_d   = '0;
          k_d     = '0;
          sum_d   = '0;
          o_sav_d = o_q;
        end
      end
      MEASURE: begin
        if (edge_w) begin
          int_d = '0;
          if ((k_q != 3'd0) && (diff_w > (t0_q >> 2))) begin
            abort_w = 1'b1;
          end else begin
            if (k_q == 3'd0) t0_d = t_w;
            sum_d = sum_nx_w;
            k_d   = k_q + 3'd1;
            if (k_q == 3'd7) begin
              if ((r_w >= (CW+1)'(3)) && (r_w <= (CW+1)'((1 << OW) - 1))) begin
                o_d = r_w[OW-1:0];
`ifdef UART_AUTOBAUD_VERIFY_EN
                state_d = VERIFY;
                miss_d  = 1'b0;
                vcnt_d  = '0;
`else
                state_d = LOCKED;
`endif
              end else begin
                abort_w = 1'b1;
              end
            end
          end
        end else if (int_q == INT_LAST) begin
          abort_w = 1'b1;
        end else begin
          int_d = int_q + CW'(1);
        end
      end
      VERIFY: begin
`ifdef UART_AUTOBAUD_VERIFY_EN
        // The first mismatching strobe is the tail of the measured character.
        if (strobe_w) begin
          if (rx_out == SYNC)  state_d = LOCKED;
          else if (miss_q)     abort_w = 1'b1;
          else                 miss_d  = 1'b1;
        end else if (vcnt_q == '1) begin
          abort_w = 1'b1;
        end else begin
          vcnt_d = vcnt_q + CW'(1);
        end
`else
        state_d = HUNT;
`endif
      end
      LOCKED: ;
      default: state_d = HUNT;
    endcase

    if (abort_w) begin
      err_d   = 1'b1;
      state_d = HUNT;
      o_d     = o_sav_q;
    end

    if (relearn) begin
      state_d = HUNT;
      err_d   = 1'b0;
      o_d     = o_q;
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
module tb_uart_autobaud;

`ifdef UART_AUTOBAUD_VERIFY_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, in, rx_clk, relearn;
  logic [7:0] rx_out;
  logic [3:0] o;
  logic       locked, err;

  always #5 clk = ~clk;

  uart_autobaud #(
    .OW(4), .CW(16), .DEF_O(8), .IDLE_MIN(16), .SYNC(8'h55)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .rx_out(rx_out), .rx_clk(rx_clk),
    .relearn(relearn), .o(o), .locked(locked), .err(err)
  );

  typedef struct {
    string      tag;
    logic [3:0] o;
    logic       locked;
    int         errs;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   err_seen = 0;
  int   exp_errs = 0;
  int   r5[10], r10[10], r20[10], rj[10];

  // Counts cycles with err high; each abort must contribute exactly one.
  always @(posedge clk) begin
    #1;
    if (err === 1'b1) err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_state(input string tag, input logic [3:0] eo, input logic el);
    exp_t e;
    e.tag = tag; e.o = eo; e.locked = el; e.errs = exp_errs;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".o"}, 32'(o), 32'(e.o));
      check({e.tag, ".locked"}, 32'(locked), 32'(e.locked));
      check({e.tag, ".errs"}, err_seen, e.errs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives alternating runs starting low; checks o just before and just
  // after the 8th line edge reaches the controller.
  task automatic send_runs(input int r[10], input logic [3:0] opre,
                           input logic [3:0] opost, input string tag);
    int e8, cyc;
    e8 = 0;
    cyc = 0;
    for (int j = 0; j < 8; j++) e8 += r[j];
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < r[j]; c++) begin
        @(negedge clk);
        if (cyc == e8 + 2) check({tag, ".o_pre"}, 32'(o), 32'(opre));
        if (cyc == e8 + 3) check({tag, ".o_post"}, 32'(o), 32'(opost));
        in = (j % 2 == 1);
        cyc++;
      end
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    rx_out = v;
    rx_clk = 1'b1;
    @(negedge clk);
    rx_clk = 1'b0;
  endtask

  task automatic pulse_relearn();
    @(negedge clk);
    relearn = 1'b1;
    @(negedge clk);
    relearn = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      r5[i] = 5; r10[i] = 10; r20[i] = 20; rj[i] = 8;
    end
    rj[3] = 13;

    rst_n = 1'b0; in = 1'b1; rx_clk = 1'b0; rx_out = 8'h00; relearn = 1'b0;
    tick(3);
    expect_state("reset", 4'd8, 1'b0);
    check_sb();
    rst_n = 1'b1;

    // Ratio 20 exceeds 4-bit range.
    tick(20);
    exp_errs++;
    expect_state("ovr", 4'd8, 1'b0);
    send_runs(r20, 4'd8, 4'd8, "ovr");
    tick(2);
    check_sb();

    // Fourth interval off by more than t0/4.
    tick(20);
    exp_errs++;
    expect_state("jit", 4'd8, 1'b0);
    send_runs(rj, 4'd8, 4'd8, "jit");
    tick(2);
    check_sb();

    // Lock at 5 clk/bit; a garbage strobe first is tolerated.
    tick(20);
    expect_state("m5", 4'd5, !VEN);
    send_runs(r5, 4'd8, 4'd5, "m5");
    check_sb();
    expect_state("garb", 4'd5, !VEN);
    strobe(8'hAA);
    check_sb();
    tick(20);
    send_runs(r5, 4'd5, 4'd5, "m5b");
    expect_state("lock5", 4'd5, 1'b1);
    strobe(8'h55);
    check_sb();

    // Reset in the middle of a measurement.
    expect_state("rl1", 4'd5, 1'b0);
    pulse_relearn();
    check_sb();
    tick(20);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in = (c >= 5 && c < 10);
    end
    expect_state("mid", 4'd5, 1'b0);
    check_sb();
    @(negedge clk);
    rst_n = 1'b0;
    in = 1'b1;
    expect_state("rstmid", 4'd8, 1'b0);
    @(negedge clk);
    check_sb();
    rst_n = 1'b1;

    tick(20);
    send_runs(r5, 4'd8, 4'd5, "relock");
    expect_state("relock", 4'd5, 1'b1);
    strobe(8'h55);
    check_sb();

    // Relearn then lock at 10 clk/bit.
    expect_state("rl2", 4'd5, 1'b0);
    pulse_relearn();
    check_sb();
    tick(20);
    send_runs(r10, 4'd5, 4'd10, "m10");
    expect_state("lock10", 4'd10, 1'b1);
    strobe(8'h55);
    check_sb();

    // Two mismatching strobes abort verification and restore o.
    pulse_relearn();
    tick(20);
    send_runs(r5, 4'd10, 4'd5, "vab");
    expect_state("vab1", 4'd5, !VEN);
    strobe(8'h12);
    check_sb();
    if (VEN) exp_errs++;
    expect_state("vab2", VEN ? 4'd10 : 4'd5, !VEN);
    strobe(8'h34);
    tick(2);
    check_sb();

    // Line stuck low after a start edge.
    expect_state("rl3", VEN ? 4'd10 : 4'd5, 1'b0);
    pulse_relearn();
    check_sb();
    tick(20);
    @(negedge clk);
    in = 1'b0;
    exp_errs++;
    tick(65545);
    in = 1'b1;
    tick(2);
    expect_state("tmo", VEN ? 4'd10 : 4'd5, 1'b0);
    check_sb();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
